data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port BIP data memory between two requesters: port 0 is the CPU datapath, port 1 is the debug/UART unit. Each cycle it grants at most one access and drives the memory's read enable, write enable, address and write data. It returns read data one cycle after the grant and tags it with the originating port. A bounded-burst round-robin policy gives a streaming requester up to `max_burst` consecutive grants before it must yield to a waiting one.

---
 rtl/data_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU datapath (port 0)
// and the debug/UART unit (port 1), with bounded-burst round-robin and tagged read return.
module data_mem_arbiter #(
  parameter int len_addr  = 11,
  parameter int len_data  = 16,
  parameter int max_burst = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_0,
  input  logic                req_1,
  input  logic                we_0,
  input  logic                we_1,
  input  logic [len_addr-1:0] addr_0,
  input  logic [len_addr-1:0] addr_1,
  input  logic [len_data-1:0] wdata_0,
  input  logic [len_data-1:0] wdata_1,
  output logic                gnt_0,
  output logic                gnt_1,
  output logic                rvalid_0,
  output logic                rvalid_1,
  output logic [len_data-1:0] rdata,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [len_addr-1:0] mem_addr,
  output logic [len_data-1:0] mem_wdata,
  input  logic [len_data-1:0] mem_rdata
);

  localparam int               CNT_W   = (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_burst);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_e;

  port_e               r_owner;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_rv_pend;
  port_e               r_rv_port;
  logic [len_addr-1:0] r_last_addr;

  port_e               w_owner_nxt;
  logic [CNT_W-1:0]    w_burst_cnt_nxt;
  logic                w_rv_pend_nxt;
  port_e               w_rv_port_nxt;
  logic [len_addr-1:0] w_last_addr_nxt;

  port_e               w_winner;
  logic                w_grant;
  logic                w_sel_we;
  logic [len_addr-1:0] w_sel_addr;
  logic [len_data-1:0] w_sel_wdata;

  // Under contention the current owner keeps the memory until its burst is used up.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_winner = r_owner;
    case ({req_1, req_0})
      2'b01:   w_winner = PORT_0;
      2'b10:   w_winner = PORT_1;
      2'b11:   w_winner = (r_burst_cnt < MAX_CNT) ? r_owner : port_e'(~r_owner);
      default: w_winner = r_owner;
    endcase
  end

  assign w_grant     = rst_n & (req_0 | req_1);
  assign w_sel_we    = (w_winner == PORT_1) ? we_1    : we_0;
  assign w_sel_addr  = (w_winner == PORT_1) ? addr_1  : addr_0;
  assign w_sel_wdata = (w_winner == PORT_1) ? wdata_1 : wdata_0;

  assign gnt_0 = w_grant & (w_winner == PORT_0);
  assign gnt_1 = w_grant & (w_winner == PORT_1);

  assign mem_rd    = w_grant & ~w_sel_we;
  assign mem_wr    = w_grant &  w_sel_we;
  // Idle cycles replay the last address so the memory output stays put.
  assign mem_addr  = w_grant ? w_sel_addr : (rst_n ? r_last_addr : '0);
  assign mem_wdata = w_grant ? w_sel_wdata : '0;

  assign rvalid_0 = rst_n & r_rv_pend & (r_rv_port == PORT_0);
  assign rvalid_1 = rst_n & r_rv_pend & (r_rv_port == PORT_1);
  assign rdata    = rst_n ? mem_rdata : '0;

  always_comb begin
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = '0;
    w_rv_pend_nxt   = w_grant & ~w_sel_we;
    w_rv_port_nxt   = r_rv_port;
    w_last_addr_nxt = r_last_addr;
    if (w_grant) begin
      w_rv_port_nxt   = w_winner;
      w_last_addr_nxt = w_sel_addr;
      if (w_winner == r_owner) begin
        w_burst_cnt_nxt = (r_burst_cnt >= MAX_CNT) ? MAX_CNT : r_burst_cnt + ONE_CNT;
      end else begin
        w_owner_nxt     = w_winner;
        w_burst_cnt_nxt = ONE_CNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      r_owner     <= PORT_0;
      r_burst_cnt <= '0;
      r_rv_pend   <= 1'b0;
      r_rv_port   <= PORT_0;
      r_last_addr <= '0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rv_pend   <= w_rv_pend_nxt;
      r_rv_port   <= w_rv_port_nxt;
      r_last_addr <= w_last_addr_nxt;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a predictor models arbitration and memory contents,
// a separate monitor matches read returns; directed scenarios then randomized traffic.
module tb_data_mem_arbiter;
  localparam int LA = 11;
  localparam int LD = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_0, req_1, we_0, we_1;
  logic [LA-1:0] addr_0, addr_1;
  logic [LD-1:0] wdata_0, wdata_1;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [LD-1:0] rdata;
  logic          mem_rd, mem_wr;
  logic [LA-1:0] mem_addr;
  logic [LD-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.len_addr(LA), .len_data(LD), .max_burst(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LD-1:0] init_word(input int i);
    if (i < 10) return 16'h00A0 + LD'(i);
    return LD'(i * 37 + 16'h5000);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: address registered every edge, write committed at the edge.
  logic [LD-1:0] ram [0:(1<<LA)-1];
  logic [LA-1:0] ram_addr_q = '0;
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1 << LA); i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
    end
    ram_addr_q <= mem_addr;
  end
  assign mem_rdata = ram[ram_addr_q];

  typedef struct {
    int            port;
    logic [LD-1:0] data;
    int            due;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      grant_log[$];

  // Predictor: arbitration rules and memory contents at transaction level.
  logic [LD-1:0] shadow [0:(1<<LA)-1];
  int            m_owner, m_streak, p_w;
  logic [LA-1:0] m_last_addr, p_a;
  logic [LD-1:0] p_d;
  logic          p_we;
  initial begin
    for (int i = 0; i < (1 << LA); i++) shadow[i] = init_word(i);
    m_owner = 0; m_streak = 0; m_last_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_gnt", {gnt_1, gnt_0}, 0);
        check("rst_mem_en", {mem_rd, mem_wr}, 0);
        check("rst_mem_addr", mem_addr, 0);
        m_owner = 0; m_streak = 0; m_last_addr = '0;
        exp_q.delete();
      end else begin
        p_w = -1;
        if (req_0 && !req_1)      p_w = 0;
        else if (req_1 && !req_0) p_w = 1;
        else if (req_0 && req_1)  p_w = (m_streak < MB) ? m_owner : 1 - m_owner;
        check("gnt", {gnt_1, gnt_0}, (p_w == 0) ? 2'b01 : (p_w == 1) ? 2'b10 : 2'b00);
        if (p_w >= 0) begin
          p_we = (p_w == 0) ? we_0 : we_1;
          p_a  = (p_w == 0) ? addr_0 : addr_1;
          p_d  = (p_w == 0) ? wdata_0 : wdata_1;
          check("mem_en", {mem_rd, mem_wr}, p_we ? 2'b01 : 2'b10);
          check("mem_addr", mem_addr, p_a);
          check("mem_wdata", mem_wdata, p_d);
          if (p_we) shadow[p_a] = p_d;
          else exp_q.push_back('{port: p_w, data: shadow[p_a], due: cyc + 1});
          grant_log.push_back(p_w);
          if (p_w == m_owner) m_streak++;
          else begin m_owner = p_w; m_streak = 1; end
          m_last_addr = p_a;
        end else begin
          check("idle_mem_en", {mem_rd, mem_wr}, 0);
          check("idle_mem_wdata", mem_wdata, 0);
          check("idle_mem_addr", mem_addr, m_last_addr);
          m_streak = 0;
        end
      end
    end
  end

  // Monitor: matches read returns against the scoreboard queue.
  rd_exp_t       m_e;
  logic [LD-1:0] last_rd0 = '0, last_rd1 = '0;
  int            rv1_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_rvalid", {rvalid_1, rvalid_0}, 0);
      check("rst_rdata", rdata, 0);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_e = exp_q.pop_front();
        check("rvalid", {rvalid_1, rvalid_0}, (m_e.port == 1) ? 2'b10 : 2'b01);
        check("rdata", rdata, m_e.data);
      end else begin
        check("no_rvalid", {rvalid_1, rvalid_0}, 0);
      end
      if (rvalid_0) last_rd0 = rdata;
      if (rvalid_1) begin last_rd1 = rdata; rv1_cnt++; end
    end
  end

  task automatic set_port(input int p, input logic r, input logic w, input logic [LA-1:0] a,
                          input logic [LD-1:0] d);
    if (p == 0) begin req_0 = r; we_0 = w; addr_0 = a; wdata_0 = d; end
    else        begin req_1 = r; we_1 = w; addr_1 = a; wdata_1 = d; end
  endtask

  // Holds a request until granted; returns just after the edge that ends the grant cycle.
  task automatic xfer(input int p, input logic w, input logic [LA-1:0] a, input logic [LD-1:0] d);
    bit done = 1'b0;
    set_port(p, 1'b1, w, a, d);
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if ((p == 0) ? gnt_0 : gnt_1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("xfer_grant_timeout", 0, 1);
    set_port(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_driver(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      xfer(p, 1'($urandom_range(0, 1)), LA'($urandom_range(0, 15)), LD'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int base, rv_base, c0;

  initial begin
    do_reset();

    // Lone port 1 streams reads of preloaded words.
    rv_base = rv1_cnt; base = grant_log.size(); c0 = cyc;
    for (int i = 0; i < 10; i++) xfer(1, 1'b0, LA'(i), '0);
    check("t_stream_cycles", cyc - c0, 10);
    idle(2);
    check("t_stream_rv1_count", rv1_cnt - rv_base, 10);
    check("t_stream_last", last_rd1, 16'h00A9);
    check("t_stream_grants", grant_log.size() - base, 10);

    // Write then read back on port 0.
    do_reset();
    rv_base = rv1_cnt;
    xfer(0, 1'b1, 11'd5, 16'h1234);
    xfer(0, 1'b0, 11'd5, '0);
    idle(2);
    check("t_wr_rd_data", last_rd0, 16'h1234);
    check("t_wr_rd_no_rv1", rv1_cnt - rv_base, 0);

    // Continuous contention after reset: bursts of four.
    do_reset();
    base = grant_log.size();
    fork
      begin repeat (8) xfer(0, 1'b0, LA'($urandom_range(0, 15)), '0); end
      begin repeat (8) xfer(1, 1'b0, LA'($urandom_range(0, 15)), '0); end
    join
    check("t_cont_len", grant_log.size() - base, 16);
    for (int i = 0; i < 16; i++) check("t_cont_seq", grant_log[base + i], (i / 4) % 2);

    // An idle cycle clears the burst.
    do_reset();
    for (int i = 0; i < 3; i++) xfer(0, 1'b0, LA'(i), '0);
    idle(1);
    base = grant_log.size();
    fork
      begin repeat (5) xfer(0, 1'b0, 11'd1, '0); end
      begin repeat (2) xfer(1, 1'b0, 11'd2, '0); end
    join
    check("t_gap_len", grant_log.size() - base, 7);
    for (int i = 0; i < 5; i++) check("t_gap_seq", grant_log[base + i], (i < 4) ? 0 : 1);

    // Write from port 1 returns nothing; port 0 sees the new word.
    rv_base = rv1_cnt;
    xfer(1, 1'b1, 11'd7, 16'hBEEF);
    xfer(0, 1'b0, 11'd7, '0);
    idle(2);
    check("t_write_no_rv1", rv1_cnt - rv_base, 0);
    check("t_write_readback", last_rd0, 16'hBEEF);

    // Reset right after a read grant suppresses the return; next tie goes to port 0.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      xfer(p, 1'b0, 11'd3, '0);
      rst_n = 1'b0;
      @(negedge clk);
      check("t_rst_rvalid", {rvalid_1, rvalid_0}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      base = grant_log.size();
      fork
        xfer(0, 1'b0, 11'd1, '0);
        xfer(1, 1'b0, 11'd2, '0);
      join
      check("t_rst_len", grant_log.size() - base, 2);
      check("t_rst_tie", grant_log[base], 0);
    end

    // Randomized mixed traffic.
    do_reset();
    fork
      rand_driver(0, 150);
      rand_driver(1, 150);
    join
    idle(4);
    check("drain_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
